// File: rtl/gpu_decode_pkg.sv
// Shared types and constants for the draw-instruction decoder.
// Holds default widths, default field offsets within a packed draw word,
// the texture/instruction-kind enums, the buffered record layout and the
// word legality rule.
package gpu_decode_pkg;

  localparam int unsigned DEF_NUM_VERT  = 3;
  localparam int unsigned DEF_COORD_W   = 8;
  localparam int unsigned DEF_COLOR_W   = 24;
  localparam int unsigned DEF_ALPHA_W   = 4;
  localparam int unsigned DEF_ERR_CNT_W = 8;
  localparam int unsigned DEF_COORDS_W  = DEF_NUM_VERT * 2 * DEF_COORD_W;
  localparam int unsigned DEF_WORD_W    = DEF_COORDS_W + DEF_COLOR_W + DEF_ALPHA_W + 6;
  localparam int unsigned DEF_VNUM_W    = $clog2(DEF_NUM_VERT + 1);

  // Field offsets inside a draw word (LSB positions), default widths
  localparam int unsigned DEF_COLOR_LSB = DEF_COORDS_W;
  localparam int unsigned DEF_ALPHA_LSB = DEF_COLOR_LSB + DEF_COLOR_W;
  localparam int unsigned DEF_TEX_LSB   = DEF_ALPHA_LSB + DEF_ALPHA_W;
  localparam int unsigned DEF_LAYER_LSB = DEF_TEX_LSB + 2;
  localparam int unsigned DEF_FILL_BIT  = DEF_LAYER_LSB + 2;
  localparam int unsigned DEF_INST_BIT  = DEF_FILL_BIT + 1;

  typedef enum logic [1:0] {
    TEX_NONE = 2'd0,
    TEX_A    = 2'd1,
    TEX_B    = 2'd2,
    TEX_RSVD = 2'd3
  } tex_code_t;

  typedef enum logic {
    LINE = 1'b0,
    POLY = 1'b1
  } inst_kind_t;

  // Decoded record at default widths
  typedef struct packed {
    inst_kind_t                inst;
    logic                      fill;
    logic [1:0]                layer;
    tex_code_t                 tex;
    logic [DEF_ALPHA_W-1:0]    alpha;
    logic [DEF_COLOR_W-1:0]    color;
    logic [DEF_COORDS_W-1:0]   coords;
    logic [DEF_VNUM_W-1:0]     vnum;
  } decoded_inst_t;

  // Reserved texture, or a textured fill with no texture selected
  function automatic logic word_illegal(input logic fill, input logic [1:0] tex);
    return (tex_code_t'(tex) == TEX_RSVD) || (fill && (tex_code_t'(tex) == TEX_NONE));
  endfunction

endpackage

// File: rtl/decode_out_buffer.sv
// Two-entry valid/ready record buffer.
// Ports: clk, n_rst (async active-low); flush clears the occupancy;
// wr_en/wr_rec append a record at the tail; ready accepts the head record;
// valid/count report occupancy; head always shows entry 0, which keeps the
// last transferred record once the buffer has drained.
module decode_out_buffer #(
  parameter int unsigned REC_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [REC_W-1:0] wr_rec,
  input  logic             ready,
  output logic             valid,
  output logic [1:0]       count,
  output logic [REC_W-1:0] head
);

  logic [REC_W-1:0] ent0_q, ent0_d;
  logic [REC_W-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q;
  logic             xfer;
  logic             wr_ok;

  // Next occupancy and entry contents; entry 0 is always the head
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    xfer   = (cnt_q != 2'd0) && ready;
    wr_ok  = wr_en && (cnt_q != 2'd2);
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({wr_ok, xfer})
        2'b01: begin
          if (cnt_q == 2'd2) ent0_d = ent1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = wr_rec;
          else               ent1_d = wr_rec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          // Head leaves while a new record arrives: occupancy unchanged
          if (cnt_q == 2'd1) begin
            ent0_d = wr_rec;
          end else begin
            ent0_d = ent1_q;
            ent1_d = wr_rec;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign valid = valid_q;
  assign count = cnt_q;
  assign head  = ent0_q;

endmodule

// File: rtl/decode_pipe.sv
// Registered draw-instruction decoder between the instruction FIFO and the
// raster/fill engines.
// Ports: clk, n_rst (async active-low); fifo_data/fifo_empty/fifo_read pop
// a FWFT FIFO; flush drops buffered records; out_valid/out_ready hand over
// decoded records (coordinates, color_code, alpha_val, texture_code,
// layer_num, inst_type, fill_type, vertice_num); err pulses for one cycle
// per dropped illegal word and err_count saturates.
module decode_pipe
  import gpu_decode_pkg::*;
#(
  parameter int unsigned NUM_VERT  = DEF_NUM_VERT,
  parameter int unsigned COORD_W   = DEF_COORD_W,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned ALPHA_W   = DEF_ALPHA_W,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W,
  localparam int unsigned COORDS_W = NUM_VERT * 2 * COORD_W,
  localparam int unsigned WORD_W   = COORDS_W + COLOR_W + ALPHA_W + 6,
  localparam int unsigned VNUM_W   = $clog2(NUM_VERT + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [WORD_W-1:0]    fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COORDS_W-1:0]  coordinates,
  output logic [COLOR_W-1:0]   color_code,
  output logic [ALPHA_W-1:0]   alpha_val,
  output logic [1:0]           texture_code,
  output logic [1:0]           layer_num,
  output logic                 inst_type,
  output logic                 fill_type,
  output logic [VNUM_W-1:0]    vertice_num,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned COLOR_LSB = COORDS_W;
  localparam int unsigned ALPHA_LSB = COLOR_LSB + COLOR_W;
  localparam int unsigned TEX_LSB   = ALPHA_LSB + ALPHA_W;
  localparam int unsigned LAYER_LSB = TEX_LSB + 2;
  localparam int unsigned FILL_BIT  = LAYER_LSB + 2;
  localparam int unsigned INST_BIT  = FILL_BIT + 1;
  localparam int unsigned REC_W     = WORD_W + VNUM_W;

  logic [1:0]        count;
  logic              legal_c;
  logic              wr_en;
  logic [VNUM_W-1:0] vnum_c;
  logic [REC_W-1:0]  wr_rec;
  logic [REC_W-1:0]  head;
  logic              drop_c;

  // Pop whenever a word is present, no flush, and a buffer slot is free
  assign fifo_read = !fifo_empty && !flush && (count < 2'd2);

  // Legality screen and vertex count of the FIFO head word
  always_comb begin
    legal_c = !word_illegal(fifo_data[FILL_BIT], fifo_data[TEX_LSB +: 2]);
    vnum_c  = (inst_kind_t'(fifo_data[INST_BIT]) == POLY) ? VNUM_W'(NUM_VERT) : VNUM_W'(2);
  end

  assign wr_en  = fifo_read && legal_c;
  assign drop_c = fifo_read && !legal_c;
  assign wr_rec = {vnum_c, fifo_data};

  decode_out_buffer #(
    .REC_W (REC_W)
  ) u_buf (
    .clk    (clk),
    .n_rst  (n_rst),
    .flush  (flush),
    .wr_en  (wr_en),
    .wr_rec (wr_rec),
    .ready  (out_ready),
    .valid  (out_valid),
    .count  (count),
    .head   (head)
  );

  // Error pulse and saturating drop counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= drop_c;
      if (drop_c && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign coordinates  = head[0 +: COORDS_W];
  assign color_code   = head[COLOR_LSB +: COLOR_W];
  assign alpha_val    = head[ALPHA_LSB +: ALPHA_W];
  assign texture_code = head[TEX_LSB +: 2];
  assign layer_num    = head[LAYER_LSB +: 2];
  assign fill_type    = head[FILL_BIT];
  assign inst_type    = head[INST_BIT];
  assign vertice_num  = head[WORD_W +: VNUM_W];

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: a queue-based reference model of the
// decoded-record stream, driven by directed sequences and random traffic.
module tb_decode_pipe;
  import gpu_decode_pkg::*;

  typedef struct packed {
    logic        inst;
    logic        fill;
    logic [1:0]  layer;
    logic [1:0]  tex;
    logic [3:0]  alpha;
    logic [23:0] color;
    logic [47:0] coords;
  } word_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [81:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] coordinates;
  logic [23:0] color_code;
  logic [3:0]  alpha_val;
  logic [1:0]  texture_code;
  logic [1:0]  layer_num;
  logic        inst_type;
  logic        fill_type;
  logic [1:0]  vertice_num;
  logic        err;
  logic [7:0]  err_count;

  decode_pipe dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .coordinates  (coordinates),
    .color_code   (color_code),
    .alpha_val    (alpha_val),
    .texture_code (texture_code),
    .layer_num    (layer_num),
    .inst_type    (inst_type),
    .fill_type    (fill_type),
    .vertice_num  (vertice_num),
    .err          (err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  word_t         src[$];   // words waiting in the instruction FIFO
  decoded_inst_t mq[$];    // records the design should be holding
  decoded_inst_t shown;    // record the outputs should present
  logic          exp_err;
  int unsigned   exp_cnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input word_t w);
    return (w.tex == 2'd3) || (w.fill && w.tex == 2'd0);
  endfunction

  function automatic decoded_inst_t to_rec(input word_t w);
    decoded_inst_t r;
    r.inst   = inst_kind_t'(w.inst);
    r.fill   = w.fill;
    r.layer  = w.layer;
    r.tex    = tex_code_t'(w.tex);
    r.alpha  = w.alpha;
    r.color  = w.color;
    r.coords = w.coords;
    r.vnum   = w.inst ? 2'(DEF_NUM_VERT) : 2'd2;
    return r;
  endfunction

  function automatic word_t rand_word();
    return word_t'(82'({$urandom, $urandom, $urandom}));
  endfunction

  function automatic word_t legal_word();
    word_t w;
    w = rand_word();
    while (is_illegal(w)) w = rand_word();
    return w;
  endfunction

  function automatic word_t illegal_word();
    word_t w;
    w = rand_word();
    if ($urandom_range(0, 1) == 0) w.tex = 2'd3;
    else begin w.fill = 1'b1; w.tex = 2'd0; end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    shown   = '0;
    exp_err = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, mq.size() != 0);
    check_eq("coordinates", coordinates, shown.coords);
    check_eq("color_code", color_code, shown.color);
    check_eq("alpha_val", alpha_val, shown.alpha);
    check_eq("texture_code", texture_code, shown.tex);
    check_eq("layer_num", layer_num, shown.layer);
    check_eq("inst_type", inst_type, shown.inst);
    check_eq("fill_type", fill_type, shown.fill);
    check_eq("vertice_num", vertice_num, shown.vnum);
    check_eq("err", err, exp_err);
    check_eq("err_count", err_count, exp_cnt);
  endtask

  // One clock: drive at negedge, check pop, advance model at posedge, check outputs
  task automatic cycle(input bit allow, input bit fl, input bit rdy);
    bit    pop;
    word_t w;
    fifo_empty = !(allow && src.size() != 0);
    fifo_data  = (src.size() != 0) ? 82'(src[0]) : 82'(rand_word());
    flush      = fl;
    out_ready  = rdy;
    #1;
    pop = !fifo_empty && !fl && (mq.size() < 2);
    check_eq("fifo_read", fifo_read, pop);
    @(posedge clk);
    if (fl) mq.delete();
    else if (mq.size() != 0 && rdy) void'(mq.pop_front());
    exp_err = 1'b0;
    if (pop) begin
      w = src.pop_front();
      if (is_illegal(w)) begin
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end else begin
        mq.push_back(to_rec(w));
      end
    end
    if (mq.size() != 0) shown = mq[0];
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_count", err_count, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    #2;
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t w;
    n_rst      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check_eq("rst_fifo_read", fifo_read, 0);
    #2;
    n_rst = 1'b1;
    @(negedge clk);

    // Basic polygon decode
    w = word_t'({1'b1, 1'b0, 2'b01, 2'b00, 4'hF, 24'hFF8000, 48'h0A0B_1C1D_2E2F});
    src.push_back(w);
    cycle(1, 0, 1);
    check_eq("basic_valid", out_valid, 1);
    check_eq("basic_coords", coordinates, 48'h0A0B1C1D2E2F);
    check_eq("basic_color", color_code, 24'hFF8000);
    check_eq("basic_alpha", alpha_val, 4'hF);
    check_eq("basic_layer", layer_num, 2'd1);
    check_eq("basic_vnum", vertice_num, 2'd3);
    check_eq("basic_err", err, 0);
    cycle(1, 0, 1);

    // Back-to-back line words
    for (int i = 0; i < 4; i++) begin
      w = legal_word();
      w.inst = 1'b0;
      src.push_back(w);
    end
    cycle(1, 0, 1);
    check_eq("line_vnum", vertice_num, 2'd2);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1);

    // Back-pressure: only two records held, then drain in order
    for (int i = 0; i < 3; i++) src.push_back(legal_word());
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    check_eq("bp_left_in_fifo", src.size(), 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1);

    // Illegal words are dropped and counted
    w = legal_word(); w.tex = 2'd3; src.push_back(w);
    w = legal_word(); w.fill = 1'b1; w.tex = 2'd0; src.push_back(w);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1);
    check_eq("illegal_count2", err_count, 8'd2);
    for (int i = 0; i < 300; i++) src.push_back(illegal_word());
    for (int i = 0; i < 302; i++) cycle(1, 0, 1);
    check_eq("err_count_sat", err_count, 8'd255);

    // Flush with a full buffer and a non-empty FIFO
    for (int i = 0; i < 4; i++) src.push_back(legal_word());
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    check_eq("flush_valid", out_valid, 0);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    cycle(1, 0, 1);

    // Asynchronous reset in mid-stream
    for (int i = 0; i < 4; i++) src.push_back(legal_word());
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    async_reset();
    for (int i = 0; i < 6; i++) cycle(1, 0, 1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (src.size() < 4 && $urandom_range(0, 9) < 6) src.push_back(rand_word());
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 10; i++) cycle(1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
